// File: rtl/gb_ifmap_pingpong.sv
// Ping-pong input-feature-map global buffer: one bank fills while the other is read.
// Optional sticky error flags are built only when GB_IFMAP_ERR_EN is defined.
module gb_ifmap_pingpong #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int RD_PORTS      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_en,
  input  logic [ADDR_BITWIDTH-1:0]          w_addr,
  input  logic [DATA_BITWIDTH-1:0]          w_data,
  input  logic                              w_last,
  input  logic [RD_PORTS-1:0]               read_req,
  input  logic [RD_PORTS*ADDR_BITWIDTH-1:0] r_addr,
  input  logic                              r_done,
  output logic [RD_PORTS*DATA_BITWIDTH-1:0] r_data,
  output logic [RD_PORTS-1:0]               r_valid,
  output logic                              wr_full,
  output logic                              rd_ready,
  output logic                              wr_sel,
  output logic [1:0]                        err
);

  localparam int DEPTH = 1 << ADDR_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] bank0 [DEPTH];
  logic [DATA_BITWIDTH-1:0] bank1 [DEPTH];

  logic wr_accept;
  logic swap;
  logic release_rd;

  // Handshake: a write is taken on any edge with write_en=1 and wr_full=0;
  // a read on port p is served on an edge with read_req[p]=1 and rd_ready=1,
  // and r_valid[p] pulses for exactly the following cycle. There is no stall.
  assign wr_accept  = write_en & ~wr_full;
  assign swap       = wr_full & ~rd_ready;
  assign release_rd = r_done & rd_ready;

  // Storage is deliberately not reset; an abandoned fill is simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (wr_sel) bank1[w_addr] <= w_data;
      else        bank0[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel   <= 1'b0;
      wr_full  <= 1'b0;
      rd_ready <= 1'b0;
    end else if (swap) begin
      wr_sel   <= ~wr_sel;
      wr_full  <= 1'b0;
      rd_ready <= 1'b1;
    end else begin
      if (wr_accept && w_last) wr_full  <= 1'b1;
      if (release_rd)          rd_ready <= 1'b0;
    end
  end

  // A swap requires rd_ready=0, so no read is ever served on a swap edge and
  // the read bank (!wr_sel) seen here is always the pre-edge read bank.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_BITWIDTH-1:0] ra;
    logic [DATA_BITWIDTH-1:0] rd_word;
    logic [DATA_BITWIDTH-1:0] rd_q;
    logic                     valid_q;

    assign ra      = r_addr[p*ADDR_BITWIDTH +: ADDR_BITWIDTH];
    assign rd_word = wr_sel ? bank0[ra] : bank1[ra];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q    <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= read_req[p] & rd_ready;
        if (read_req[p] && rd_ready) rd_q <= rd_word;
      end
    end

    assign r_data[p*DATA_BITWIDTH +: DATA_BITWIDTH] = rd_q;
    assign r_valid[p] = valid_q;
  end

`ifdef GB_IFMAP_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      if (write_en && wr_full)          err_q[0] <= 1'b1;
      if ((|read_req) && !rd_ready)     err_q[1] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule
